// File: rtl/gsm_burst_pkg.sv
// GSM normal-burst formatter shared types: burst state enum, section order, TSC ROM.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gsm_burst_pkg;

  localparam int unsigned TRAIN_BITS = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD_TAIL,
    ST_PAY1,
    ST_TRAIN,
    ST_PAY2,
    ST_TAIL_TAIL,
    ST_GUARD
  } burst_state_t;

  // Section that follows the given one; GUARD wraps back to IDLE.
  function automatic burst_state_t next_section(input burst_state_t s);
    case (s)
      ST_HEAD_TAIL: next_section = ST_PAY1;
      ST_PAY1:      next_section = ST_TRAIN;
      ST_TRAIN:     next_section = ST_PAY2;
      ST_PAY2:      next_section = ST_TAIL_TAIL;
      ST_TAIL_TAIL: next_section = ST_GUARD;
      default:      next_section = ST_IDLE;
    endcase
  endfunction

  // GSM 05.02 normal-burst training sequences, bit 25 transmitted first.
  function automatic logic [TRAIN_BITS-1:0] tsc_word(input logic [2:0] sel);
    case (sel)
      3'd0:    tsc_word = 26'h0970897;
      3'd1:    tsc_word = 26'h0B778B7;
      3'd2:    tsc_word = 26'h10EE90E;
      3'd3:    tsc_word = 26'h11ED11E;
      3'd4:    tsc_word = 26'h06B906B;
      3'd5:    tsc_word = 26'h13AC13A;
      3'd6:    tsc_word = 26'h29F629F;
      default: tsc_word = 26'h3BC4BBC;
    endcase
  endfunction

endpackage

// File: rtl/gsm_diff_encoder.sv
// Differential encoder: symbol = b XOR b_prev, registered, b_prev tracks b.
// Latency: 1 cycle from enable to symbol update; symbol holds between enables.
// Backpressure: none; advances only when the parent enables it.
//   clock, reset_n : clock and async active-low reset
//   load_one       : force b_prev=1 (burst start), symbol untouched
//   enc_en         : encode bit_in and update b_prev
//   zero_en        : emit symbol 0 without disturbing b_prev (idle strobes)
//   symbol         : registered encoded symbol
module gsm_diff_encoder (
  input  logic clock,
  input  logic reset_n,
  input  logic load_one,
  input  logic enc_en,
  input  logic zero_en,
  input  logic bit_in,
  output logic symbol
);

  logic b_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      b_prev <= 1'b1;
      symbol <= 1'b0;
    end else if (load_one) begin
      b_prev <= 1'b1;
    end else if (enc_en) begin
      symbol <= bit_in ^ b_prev;
      b_prev <= bit_in;
    end else if (zero_en) begin
      symbol <= 1'b0;
    end
  end

endmodule

// File: rtl/gsm_burst_formatter.sv
// GSM normal-burst formatter: tails, 2x payload halves, TSC, guard, differentially encoded.
// Latency: one symbol per symbol_strobe_i, next_symbol_o updates 1 cycle after the strobe.
// Backpressure: payload popped only on PAY strobes; missing payload is zero-filled and flagged.
//   clock, reset_n                 : clock, async active-low reset
//   start_burst_i, tsc_i           : burst request (idle only) and training code
//   payload_bit_i/valid_i/ready_o  : payload stream, ready is a same-cycle pop pulse
//   symbol_strobe_i, next_symbol_o : modulator symbol request and encoded symbol
//   busy_o, burst_done_o, underrun_o : status
module gsm_burst_formatter
  import gsm_burst_pkg::*;
#(
  parameter int unsigned GUARD_SYMBOLS     = 8,
  parameter int unsigned TAIL_BITS         = 3,
  parameter int unsigned HALF_PAYLOAD_BITS = 58
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_burst_i,
  input  logic [2:0] tsc_i,
  input  logic       payload_bit_i,
  input  logic       payload_valid_i,
  output logic       payload_ready_o,
  input  logic       symbol_strobe_i,
  output logic       next_symbol_o,
  output logic       busy_o,
  output logic       burst_done_o,
  output logic       underrun_o
);

  burst_state_t state, state_nxt;
  logic [6:0]   cnt, cnt_nxt;
  logic [2:0]   tsc_sel, tsc_sel_nxt;
  logic         underrun_nxt;
  logic         done_nxt;
  logic         load_one, enc_en, zero_en, raw_bit;
  logic [6:0]   sec_len;
  logic [4:0]   tsc_idx;
  logic [TRAIN_BITS-1:0] tsc_bits;

  always_comb begin
    case (state)
      ST_HEAD_TAIL, ST_TAIL_TAIL: sec_len = 7'(TAIL_BITS);
      ST_PAY1, ST_PAY2:           sec_len = 7'(HALF_PAYLOAD_BITS);
      ST_TRAIN:                   sec_len = 7'(TRAIN_BITS);
      ST_GUARD:                   sec_len = 7'(GUARD_SYMBOLS);
      default:                    sec_len = 7'd1;
    endcase
  end

  assign tsc_bits = tsc_word(tsc_sel);
  // Counter runs 0..25 in TRAIN; MSB goes out first.
  assign tsc_idx  = 5'(TRAIN_BITS - 1) - cnt[4:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      tsc_sel      <= '0;
      underrun_o   <= 1'b0;
      burst_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      tsc_sel      <= tsc_sel_nxt;
      underrun_o   <= underrun_nxt;
      burst_done_o <= done_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    tsc_sel_nxt     = tsc_sel;
    underrun_nxt    = underrun_o;
    done_nxt        = 1'b0;
    load_one        = 1'b0;
    enc_en          = 1'b0;
    zero_en         = 1'b0;
    raw_bit         = 1'b0;
    payload_ready_o = 1'b0;

    if (state == ST_IDLE) begin
      if (start_burst_i) begin
        tsc_sel_nxt  = tsc_i;
        underrun_nxt = 1'b0;
        load_one     = 1'b1;
        cnt_nxt      = '0;
        state_nxt    = ST_HEAD_TAIL;
      end else if (symbol_strobe_i) begin
        zero_en = 1'b1;
      end
    end else if (symbol_strobe_i) begin
      enc_en = 1'b1;
      case (state)
        ST_PAY1, ST_PAY2: begin
          if (payload_valid_i) begin
            raw_bit         = payload_bit_i;
            payload_ready_o = 1'b1;
          end else begin
            // Zero-fill and keep going so the burst never stretches.
            underrun_nxt = 1'b1;
          end
        end
        ST_TRAIN: raw_bit = tsc_bits[tsc_idx];
        default:  raw_bit = 1'b0;
      endcase
      if (cnt == sec_len - 7'd1) begin
        cnt_nxt   = '0;
        state_nxt = next_section(state);
        done_nxt  = (state == ST_GUARD);
      end else begin
        cnt_nxt = cnt + 7'd1;
      end
    end
  end

  assign busy_o = (state != ST_IDLE);

  gsm_diff_encoder u_enc (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_one (load_one),
    .enc_en   (enc_en),
    .zero_en  (zero_en),
    .bit_in   (raw_bit),
    .symbol   (next_symbol_o)
  );

endmodule

// File: tb/tb_gsm_burst_formatter.sv
module tb_gsm_burst_formatter;

  localparam int T  = 3;
  localparam int H  = 58;
  localparam int TR = 26;
  localparam int G  = 8;
  localparam int N  = 2*T + 2*H + TR + G;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_burst_i = 1'b0;
  logic [2:0] tsc_i = 3'd0;
  logic       payload_bit_i = 1'b0;
  logic       payload_valid_i = 1'b0;
  logic       payload_ready_o;
  logic       symbol_strobe_i = 1'b0;
  logic       next_symbol_o;
  logic       busy_o;
  logic       burst_done_o;
  logic       underrun_o;

  int n_pass = 0;
  int n_total = 0;
  int ready_seen = 0;
  int done_seen = 0;

  string tsc_tab [8] = '{
    "00100101110000100010010111",
    "00101101110111100010110111",
    "01000011101110100100001110",
    "01000111101101000100011110",
    "00011010111001000001101011",
    "01001110101100000100111010",
    "10100111110110001010011111",
    "11101111000100101110111100"
  };

  gsm_burst_formatter dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start_burst_i   (start_burst_i),
    .tsc_i           (tsc_i),
    .payload_bit_i   (payload_bit_i),
    .payload_valid_i (payload_valid_i),
    .payload_ready_o (payload_ready_o),
    .symbol_strobe_i (symbol_strobe_i),
    .next_symbol_o   (next_symbol_o),
    .busy_o          (busy_o),
    .burst_done_o    (burst_done_o),
    .underrun_o      (underrun_o)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (payload_ready_o) ready_seen++;
    if (burst_done_o) done_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit is_pay(input int k);
    return (k >= T && k < T + H) || (k >= T + H + TR && k < T + 2*H + TR);
  endfunction

  // mode: 0 all-zero payload, 1 alternating 1,0,..., 2 random.
  // Payload missing on strobes ur_lo..ur_hi; second start (tsc alt_tsc) at strobe mid_at;
  // reset asserted just before strobe rst_at.
  task automatic run_burst(input string name, input int tsc_idx, input int mode,
                           input int ur_lo, input int ur_hi, input int mid_at,
                           input int alt_tsc, input int rst_at);
    bit pv [N];
    bit pb [N];
    bit raw [N];
    bit exp_sym [N];
    int exp_ready = 0;
    int pcount = 0;
    bit exp_under = 0;
    int r0, d0;

    for (int k = 0; k < N; k++) begin
      pv[k] = !(k >= ur_lo && k <= ur_hi);
      case (mode)
        0: pb[k] = 1'b0;
        1: pb[k] = 1'b0;
        default: pb[k] = 1'($urandom_range(0, 1));
      endcase
    end
    // Burst bit sequence built from the section layout.
    for (int k = 0; k < N; k++) begin
      if (is_pay(k)) begin
        if (mode == 1) pb[k] = (pcount % 2 == 0);
        pcount++;
        raw[k] = pv[k] ? pb[k] : 1'b0;
        if (pv[k]) exp_ready++;
        else exp_under = 1'b1;
      end else if (k >= T + H && k < T + H + TR) begin
        raw[k] = (tsc_tab[tsc_idx][k - T - H] == 8'h31);
      end else begin
        raw[k] = 1'b0;
      end
      exp_sym[k] = raw[k] ^ ((k == 0) ? 1'b1 : raw[k-1]);
    end

    @(posedge clock); #1;
    start_burst_i = 1'b1;
    tsc_i = 3'(tsc_idx);
    @(posedge clock); #1;
    start_burst_i = 1'b0;
    tsc_i = 3'(alt_tsc);
    check({name, "_busy_start"}, 32'(busy_o), 32'd1);
    check({name, "_under_clr"}, 32'(underrun_o), 32'd0);
    r0 = ready_seen;
    d0 = done_seen;

    for (int k = 0; k < N; k++) begin
      @(posedge clock); #1;
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        check({name, "_rst_sym"}, 32'(next_symbol_o), 32'd0);
        check({name, "_rst_busy"}, 32'(busy_o), 32'd0);
        check({name, "_rst_under"}, 32'(underrun_o), 32'd0);
        check({name, "_rst_done"}, 32'(burst_done_o), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
      payload_valid_i = pv[k];
      payload_bit_i = pb[k];
      symbol_strobe_i = 1'b1;
      if (k == mid_at) start_burst_i = 1'b1;
      #1;
      check($sformatf("%s_ready%0d", name, k), 32'(payload_ready_o),
            32'(is_pay(k) && pv[k]));
      @(posedge clock); #1;
      symbol_strobe_i = 1'b0;
      start_burst_i = 1'b0;
      payload_valid_i = 1'b0;
      check($sformatf("%s_sym%0d", name, k), 32'(next_symbol_o), 32'(exp_sym[k]));
      check($sformatf("%s_busy%0d", name, k), 32'(busy_o), 32'(k != N - 1));
      if (k == N - 1) check({name, "_done_pulse"}, 32'(burst_done_o), 32'd1);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
    repeat (2) @(posedge clock);
    #1;
    check({name, "_sym_hold"}, 32'(next_symbol_o), 32'(exp_sym[N-1]));
    check({name, "_under_end"}, 32'(underrun_o), 32'(exp_under));
    check({name, "_ready_cnt"}, 32'(ready_seen - r0), 32'(exp_ready));
    check({name, "_done_cnt"}, 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    int r0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("reset_sym", 32'(next_symbol_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(burst_done_o), 32'd0);
    check("reset_under", 32'(underrun_o), 32'd0);
    check("reset_ready", 32'(payload_ready_o), 32'd0);

    // Strobes with no burst: continuous zeros, no pops.
    r0 = ready_seen;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      payload_valid_i = 1'b1;
      symbol_strobe_i = 1'b1;
      @(posedge clock); #1;
      symbol_strobe_i = 1'b0;
      payload_valid_i = 1'b0;
      check($sformatf("idle_sym%0d", k), 32'(next_symbol_o), 32'd0);
      check($sformatf("idle_busy%0d", k), 32'(busy_o), 32'd0);
    end
    check("idle_ready_cnt", 32'(ready_seen - r0), 32'd0);

    run_burst("zero",  0, 0, -1, -1, -1, 0, -1);
    run_burst("alt",   1, 1, -1, -1, -1, 1, -1);
    run_burst("under", 3, 2, 10, 12, -1, 3, -1);
    run_burst("midst", 5, 2, -1, -1, 70, 2, -1);
    run_burst("rst",   6, 2, -1, -1, -1, 6, 70);
    run_burst("fresh", 7, 2, -1, -1, -1, 4, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
